// File: rtl/key_op_selector.sv
// key_op_selector: push-button front end for the Lab2 calculator datapath.
// Raw active-low KEY[2:0] go through a 2-flop synchronizer, a per-key
// debouncer, press-edge detection and a press/hold FSM. The FSM produces a
// registered OpCode and a one-cycle op_valid per accepted press.
// Build option: define KEY_OPERAND_LATCH_EN to snapshot sw_x/sw_y into
// A_lat/B_lat on the accepted press; left undefined, A_lat/B_lat follow the
// switches combinationally.
module key_op_selector #(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   KEY,
   input  logic [N-1:0] sw_x,
   input  logic [N-1:0] sw_y,
   output logic [3:0]   op_sel,
   output logic [N-1:0] A_lat,
   output logic [N-1:0] B_lat,
   output logic         op_valid,
   output logic         busy
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_MULT = 4'b0010,
      OP_NONE = 4'b1111
   } op_code_e;

   typedef enum logic {
      S_IDLE,
      S_HELD
   } state_e;

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // Counter value from which the next increment would reach DEBOUNCE_CYCLES.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [2:0]    r_sync1;
   logic [2:0]    r_sync2;
   logic [CW-1:0] r_cnt [3];
   logic [2:0]    r_stable;
   logic [2:0]    r_stable_d;
   logic [2:0]    r_press;

   state_e        r_state;
   state_e        w_state_nxt;
   op_code_e      r_op;
   op_code_e      w_op_nxt;
   logic          r_op_valid;
   logic          w_op_valid_nxt;
   logic          w_accept;

   // Two-flop synchronizer; reset to the released (high) level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= KEY;
         r_sync2 <= r_sync1;
      end
   end

   // Per-key debounce: the stable level flips only after the synchronized
   // level has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 3; i++) begin
            r_cnt[i] <= '0;
         end
         r_stable <= '1;
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Registered single-cycle press strobe on each stable 1->0 transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stable_d <= '1;
         r_press    <= '0;
      end else begin
         r_stable_d <= r_stable;
         r_press    <= r_stable_d & ~r_stable;
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_op       <= OP_NONE;
         r_op_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_op       <= w_op_nxt;
         r_op_valid <= w_op_valid_nxt;
      end
   end

   // Next-state logic: accept one press by priority Add > Sub > Mult in IDLE,
   // ignore everything in HELD until all keys are debounced as released.
   always_comb begin
      w_state_nxt    = r_state;
      w_op_nxt       = r_op;
      w_op_valid_nxt = 1'b0;
      w_accept       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|r_press) begin
               w_accept       = 1'b1;
               w_op_valid_nxt = 1'b1;
               w_state_nxt    = S_HELD;
               if (r_press[2]) begin
                  w_op_nxt = OP_ADD;
               end else if (r_press[1]) begin
                  w_op_nxt = OP_SUB;
               end else begin
                  w_op_nxt = OP_MULT;
               end
            end
         end
         S_HELD: begin
            if (&r_stable) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef KEY_OPERAND_LATCH_EN
   logic [N-1:0] r_a;
   logic [N-1:0] r_b;

   // Operand snapshot taken on the same edge that raises op_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
      end else if (w_accept) begin
         r_a <= sw_x;
         r_b <= sw_y;
      end
   end

   assign A_lat = r_a;
   assign B_lat = r_b;
`else
   logic w_accept_unused;

   assign w_accept_unused = w_accept;
   assign A_lat           = sw_x;
   assign B_lat           = sw_y;
`endif

   assign op_sel   = r_op;
   assign op_valid = r_op_valid;
   assign busy     = (r_state == S_HELD);

endmodule

// File: tb/tb_key_op_selector.sv
// Self-checking bench for key_op_selector with DEBOUNCE_CYCLES=4.
// Expected outputs come from a history-based reference model: a key's
// debounced level flips once its last DEBOUNCE_CYCLES synchronized samples
// all disagree with it; a fall is acted on two edges later.
module tb_key_op_selector;

   localparam int D = 4;
   localparam int N = 4;
   localparam logic [3:0] C_ADD  = 4'h0;
   localparam logic [3:0] C_SUB  = 4'h1;
   localparam logic [3:0] C_MULT = 4'h2;
   localparam logic [3:0] C_NONE = 4'hF;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   KEY;
   logic [N-1:0] sw_x;
   logic [N-1:0] sw_y;
   logic [3:0]   op_sel;
   logic [N-1:0] A_lat;
   logic [N-1:0] B_lat;
   logic         op_valid;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   key_op_selector #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .KEY(KEY), .sw_x(sw_x), .sw_y(sw_y),
      .op_sel(op_sel), .A_lat(A_lat), .B_lat(B_lat),
      .op_valid(op_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [2:0]   hist [$];
   logic [2:0]   m_stable = 3'b111;
   logic [2:0]   fell1 = 3'b000;
   logic [2:0]   fell2 = 3'b000;
   logic         m_held = 1'b0;
   logic [3:0]   m_op = C_NONE;
   logic [N-1:0] m_a = '0;
   logic [N-1:0] m_b = '0;
   logic         m_valid = 1'b0;

   always @(posedge clk) begin : model
      logic [2:0] newst;
      logic       all_diff;
      if (rst) begin
         hist.delete();
         for (int k = 0; k < D + 2; k++) hist.push_back(3'b111);
         m_stable = 3'b111;
         fell1 = 3'b000;
         fell2 = 3'b000;
         m_held = 1'b0;
         m_op = C_NONE;
         m_a = '0;
         m_b = '0;
         m_valid = 1'b0;
      end else begin
         hist.push_back(KEY);
         if (hist.size() > 64) void'(hist.pop_front());
         m_valid = 1'b0;
         if (!m_held) begin
            if (fell2 != 3'b000) begin
               m_valid = 1'b1;
               m_held  = 1'b1;
               m_a = sw_x;
               m_b = sw_y;
               m_op = fell2[2] ? C_ADD : (fell2[1] ? C_SUB : C_MULT);
            end
         end else if (m_stable == 3'b111) begin
            m_held = 1'b0;
         end
         newst = m_stable;
         for (int i = 0; i < 3; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++)
               if (hist[hist.size() - 3 - k][i] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) newst[i] = ~m_stable[i];
         end
         fell2 = fell1;
         fell1 = m_stable & ~newst;
         m_stable = newst;
      end
   end

   function automatic logic [N-1:0] exp_a();
`ifdef KEY_OPERAND_LATCH_EN
      return m_a;
`else
      return sw_x;
`endif
   endfunction

   function automatic logic [N-1:0] exp_b();
`ifdef KEY_OPERAND_LATCH_EN
      return m_b;
`else
      return sw_y;
`endif
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; KEY = 3'b111; sw_x = 4'h5; sw_y = 4'hA;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         n_checks++;
         if (op_sel !== C_NONE) begin n_fail++; $display("FAIL reset_op_sel: got %h expected %h", op_sel, C_NONE); end
         n_checks++;
         if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid: got %b expected 0", op_valid); end
         n_checks++;
         if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
         n_checks++;
         if (A_lat !== exp_a() || B_lat !== exp_b()) begin
            n_fail++; $display("FAIL reset_operands: got %h/%h expected %h/%h", A_lat, B_lat, exp_a(), exp_b());
         end
`ifdef KEY_OPERAND_LATCH_EN
         n_checks++;
         if (A_lat !== 4'h0 || B_lat !== 4'h0) begin n_fail++; $display("FAIL reset_latch_zero: got %h/%h expected 0/0", A_lat, B_lat); end
`endif
         sw_x = 4'($urandom); sw_y = 4'($urandom);
      end
   endtask

   task automatic test_add_press();
      @(negedge clk);
      sw_x = 4'b0011; sw_y = 4'b1110; KEY = 3'b011;
      for (int j = 0; j < 35; j++) begin
         @(negedge clk);
         n_checks++;
         if (op_valid !== (j == 7)) begin n_fail++; $display("FAIL add_valid_timing j=%0d: got %b expected %b", j, op_valid, (j == 7)); end
         n_checks++;
         if (op_valid !== m_valid || busy !== m_held) begin
            n_fail++; $display("FAIL add_model j=%0d: got v=%b b=%b expected v=%b b=%b", j, op_valid, busy, m_valid, m_held);
         end
         if (j == 7) begin
            n_checks++;
            if (op_sel !== C_ADD || A_lat !== 4'd3 || B_lat !== 4'b1110) begin
               n_fail++; $display("FAIL add_result: got %h %h %h expected %h 3 e", op_sel, A_lat, B_lat, C_ADD);
            end
         end
         if (j == 10) begin
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_held: got %b expected 1", busy); end
         end
         if (j == 19) KEY = 3'b111;
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_release: got %b expected 0", busy); end
   endtask

   task automatic test_bounce();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         n_checks++;
         if (op_valid !== 1'b0 || op_sel !== C_ADD) begin
            n_fail++; $display("FAIL bounce c=%0d: got v=%b op=%h expected v=0 op=%h", c, op_valid, op_sel, C_ADD);
         end
         KEY = (c < 30 && (c % 6) < 3) ? 3'b101 : 3'b111;
      end
   endtask

   task automatic test_simultaneous();
      int pulses;
      pulses = 0;
      @(negedge clk);
      KEY = 3'b100;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         if (op_valid === 1'b1) pulses++;
         n_checks++;
         if (op_valid !== m_valid) begin n_fail++; $display("FAIL simul_model c=%0d: got %b expected %b", c, op_valid, m_valid); end
         if (c == 13) KEY = 3'b111;
      end
      n_checks++;
      if (pulses != 1 || op_sel !== C_SUB) begin n_fail++; $display("FAIL simul_sub: got pulses=%0d op=%h expected 1 %h", pulses, op_sel, C_SUB); end
      pulses = 0;
      KEY = 3'b110;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         if (op_valid === 1'b1) pulses++;
         if (c == 13) KEY = 3'b111;
      end
      n_checks++;
      if (pulses != 1 || op_sel !== C_MULT) begin n_fail++; $display("FAIL simul_mult: got pulses=%0d op=%h expected 1 %h", pulses, op_sel, C_MULT); end
   endtask

   task automatic test_hold_ignore();
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      sw_x = 4'd9; sw_y = 4'd6; KEY = 3'b011;
      for (int c = 0; c < 15 && !seen; c++) begin
         @(negedge clk);
         if (op_valid === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL hold_first_press: got no op_valid expected one within 15 cycles"); end
      KEY = 3'b010;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_checks++;
         if (op_valid !== 1'b0 || op_sel !== C_ADD || busy !== 1'b1) begin
            n_fail++; $display("FAIL hold_ignore c=%0d: got v=%b op=%h busy=%b expected v=0 op=%h busy=1", c, op_valid, op_sel, busy, C_ADD);
         end
         n_checks++;
         if (A_lat !== exp_a()) begin n_fail++; $display("FAIL hold_operand c=%0d: got %h expected %h", c, A_lat, exp_a()); end
`ifdef KEY_OPERAND_LATCH_EN
         n_checks++;
         if (A_lat !== 4'd9) begin n_fail++; $display("FAIL hold_latched_a c=%0d: got %h expected 9", c, A_lat); end
`endif
         if (c == 9) KEY = 3'b011;
         if (c == 5) sw_x = 4'd1;
      end
      KEY = 3'b111;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      KEY = 3'b101;
      repeat (14) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || op_sel !== C_SUB) begin n_fail++; $display("FAIL rstmid_pre: got busy=%b op=%h expected 1 %h", busy, op_sel, C_SUB); end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (op_sel !== C_NONE || op_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_values: got op=%h v=%b busy=%b expected %h 0 0", op_sel, op_valid, busy, C_NONE);
      end
`ifdef KEY_OPERAND_LATCH_EN
      n_checks++;
      if (A_lat !== 4'h0 || B_lat !== 4'h0) begin n_fail++; $display("FAIL rstmid_latch: got %h/%h expected 0/0", A_lat, B_lat); end
`endif
      rst = 1'b0;
      for (int j = 0; j < 14; j++) begin
         @(negedge clk);
         n_checks++;
         if (op_valid !== (j == 7)) begin n_fail++; $display("FAIL rstmid_valid j=%0d: got %b expected %b", j, op_valid, (j == 7)); end
         if (j == 7) begin
            n_checks++;
            if (op_sel !== C_SUB) begin n_fail++; $display("FAIL rstmid_op: got %h expected %h", op_sel, C_SUB); end
         end
      end
      KEY = 3'b111;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_random();
      logic prev_valid;
      int   len;
      prev_valid = 1'b0;
      for (int s = 0; s < 80; s++) begin
         KEY  = 3'($urandom);
         sw_x = 4'($urandom);
         sw_y = 4'($urandom);
         len  = $urandom_range(1, 9);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            n_checks++;
            if (op_valid !== m_valid || op_sel !== m_op || busy !== m_held) begin
               n_fail++; $display("FAIL random_ctrl s=%0d: got v=%b op=%h b=%b expected v=%b op=%h b=%b",
                                  s, op_valid, op_sel, busy, m_valid, m_op, m_held);
            end
            n_checks++;
            if (A_lat !== exp_a() || B_lat !== exp_b()) begin
               n_fail++; $display("FAIL random_operands s=%0d: got %h/%h expected %h/%h", s, A_lat, B_lat, exp_a(), exp_b());
            end
            n_checks++;
            if (prev_valid === 1'b1 && op_valid === 1'b1) begin n_fail++; $display("FAIL random_double_pulse s=%0d: got 2 cycles expected 1", s); end
            prev_valid = op_valid;
         end
      end
   endtask

   initial begin
      rst = 1'b1; KEY = 3'b111; sw_x = '0; sw_y = '0;
      test_reset();
      test_add_press();
      test_bounce();
      test_simultaneous();
      test_hold_ignore();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
